// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage FP adder operand alignment with exact sticky, subnormal handling and special bypass flag.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [MAN_W-1:0]   man_a,
  input  logic [MAN_W-1:0]   man_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   exp_out,
  output logic [MAN_W+3:0]   aligned_a,
  output logic [MAN_W+3:0]   aligned_b,
  output logic               b_larger,
  output logic               bypass,
  output logic               sign_a_out,
  output logic               sign_b_out,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int AW = MAN_W + 4;
  logic [EXP_W-1:0] effA, effB, diff;
  logic bExpGreater, special, s2Free, lost;
  logic s1Valid, s1ShiftA, s1BLarger, s1Bypass, s1SignA, s1SignB;
  logic [EXP_W-1:0] s1Diff, s1Exp;
  logic [AW-1:0] s1WA, s1WB, shiftIn, shifted;
  logic [TAG_W-1:0] s1Tag;
  always_comb begin
    effA = (exp_a == '0) ? EXP_W'(1) : exp_a;
    effB = (exp_b == '0) ? EXP_W'(1) : exp_b;
    bExpGreater = effB > effA;
    diff = bExpGreater ? effB - effA : effA - effB;
    special = (&exp_a) | (&exp_b) | (exp_a == '0 && man_a == '0) | (exp_b == '0 && man_b == '0);
    s2Free = !out_valid | out_ready;
    in_ready = !s1Valid | s2Free;
    shiftIn = s1ShiftA ? s1WA : s1WB;
    // Mask of every bit that falls off the bottom; folded into the sticky position.
    lost = |(shiftIn & ~({AW{1'b1}} << s1Diff));
    shifted = (32'(s1Diff) >= 32'(AW)) ? {{(AW-1){1'b0}}, |shiftIn}
                                       : (shiftIn >> s1Diff) | AW'(lost);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1ShiftA <= 1'b0;
      s1BLarger <= 1'b0;
      s1Bypass <= 1'b0;
      s1SignA <= 1'b0;
      s1SignB <= 1'b0;
      s1Diff <= '0;
      s1Exp <= '0;
      s1WA <= '0;
      s1WB <= '0;
      s1Tag <= '0;
      out_valid <= 1'b0;
      exp_out <= '0;
      aligned_a <= '0;
      aligned_b <= '0;
      b_larger <= 1'b0;
      bypass <= 1'b0;
      sign_a_out <= 1'b0;
      sign_b_out <= 1'b0;
      out_tag <= '0;
    end else begin
      if (in_ready) begin
        s1Valid <= in_valid;
        if (in_valid) begin
          s1ShiftA <= bExpGreater;
          s1Diff <= diff;
          s1Exp <= (exp_a == '0 && exp_b == '0) ? '0 : (bExpGreater ? effB : effA);
          s1BLarger <= bExpGreater | (effA == effB && man_b > man_a);
          s1Bypass <= special;
          s1SignA <= sign_a;
          s1SignB <= sign_b;
          s1WA <= {|exp_a, man_a, 3'b000};
          s1WB <= {|exp_b, man_b, 3'b000};
          s1Tag <= in_tag;
        end
      end
      if (s2Free) begin
        out_valid <= s1Valid;
        if (s1Valid) begin
          exp_out <= s1Exp;
          aligned_a <= s1ShiftA ? shifted : s1WA;
          aligned_b <= s1ShiftA ? s1WB : shifted;
          b_larger <= s1BLarger;
          bypass <= s1Bypass;
          sign_a_out <= s1SignA;
          sign_b_out <= s1SignB;
          out_tag <= s1Tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: directed literal cases, flow control, mid-op reset and random traffic against an arithmetic reference model.
module tb_fp_align_pipe;
  localparam int EW = 8, MW = 23, TW = 4, AW = 27;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, sign_a = 0, sign_b = 0;
  logic [EW-1:0] exp_a = 0, exp_b = 0;
  logic [MW-1:0] man_a = 0, man_b = 0;
  logic [TW-1:0] in_tag = 0;
  logic in_ready, out_valid, b_larger, bypass, sign_a_out, sign_b_out;
  logic [EW-1:0] exp_out;
  logic [AW-1:0] aligned_a, aligned_b;
  logic [TW-1:0] out_tag;

  fp_align_pipe #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .man_a(man_a), .man_b(man_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
    .aligned_a(aligned_a), .aligned_b(aligned_b), .b_larger(b_larger),
    .bypass(bypass), .sign_a_out(sign_a_out), .sign_b_out(sign_b_out), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] e;
    logic [26:0] a, b;
    logic bl, byp, sa, sb;
    logic [3:0] tag;
  } res_t;

  int nChecks = 0, nFails = 0;
  res_t q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t dutOut();
    return {exp_out, aligned_a, aligned_b, b_larger, bypass, sign_a_out, sign_b_out, out_tag};
  endfunction

  function automatic res_t mk(input logic [7:0] e, input logic [26:0] a, b,
                              input logic bl, byp, sa, sb, input logic [3:0] tag);
    return {e, a, b, bl, byp, sa, sb, tag};
  endfunction

  function automatic longint alignW(input longint w, input int d);
    if (d >= AW) return (w != 0) ? 1 : 0;
    return (w / (longint'(1) << d)) | (((w % (longint'(1) << d)) != 0) ? 1 : 0);
  endfunction

  function automatic res_t model(input logic [7:0] ea, eb, input logic [22:0] ma, mb,
                                 input logic sa, sb, input logic [3:0] tg);
    int effA, effB;
    longint wa, wb;
    res_t r;
    effA = (ea == 0) ? 1 : int'(ea);
    effB = (eb == 0) ? 1 : int'(eb);
    wa = ((ea != 0) ? 64'h4000000 : 0) + longint'(ma) * 8;
    wb = ((eb != 0) ? 64'h4000000 : 0) + longint'(mb) * 8;
    r.e = (ea == 0 && eb == 0) ? 8'd0 : 8'((effA >= effB) ? effA : effB);
    r.bl = (effB > effA) || (effB == effA && mb > ma);
    r.byp = (ea == 8'hFF) || (eb == 8'hFF) || (ea == 0 && ma == 0) || (eb == 0 && mb == 0);
    if (effA >= effB) begin
      r.a = 27'(wa);
      r.b = 27'(alignW(wb, effA - effB));
    end else begin
      r.a = 27'(alignW(wa, effB - effA));
      r.b = 27'(wb);
    end
    r.sa = sa;
    r.sb = sb;
    r.tag = tg;
    return r;
  endfunction

  // Scoreboard: order, value and hold-under-stall checks on every cycle.
  initial begin
    res_t held, e;
    logic stalled;
    stalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        stalled = 0;
      end else begin
        if (stalled) check("hold while stalled", {out_valid, dutOut()}, {1'b1, held});
        if (out_valid && q.size() == 0) check("spurious out_valid", out_valid, 0);
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          check("output vs model", dutOut(), e);
        end
        if (in_valid && in_ready)
          q.push_back(model(exp_a, exp_b, man_a, man_b, sign_a, sign_b, in_tag));
        stalled = out_valid && !out_ready;
        held = dutOut();
      end
    end
  end

  task automatic sendOp(input logic [7:0] ea, input logic [22:0] ma, input logic [7:0] eb,
                        input logic [22:0] mb, input logic sa, sb, input logic [3:0] tg);
    int n;
    in_valid = 1; exp_a = ea; man_a = ma; exp_b = eb; man_b = mb;
    sign_a = sa; sign_b = sb; in_tag = tg;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic runOne(input string name, input logic [7:0] ea, input logic [22:0] ma,
                        input logic [7:0] eb, input logic [22:0] mb, input logic sa, sb,
                        input logic [3:0] tg, input res_t ex);
    int lat;
    sendOp(ea, ma, eb, mb, sa, sb, tg);
    in_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
    check({name, " latency"}, lat, 2);
    check(name, dutOut(), ex);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rexp();
    int r;
    r = $urandom_range(0, 9);
    return (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [22:0] rman();
    int r;
    r = $urandom_range(0, 3);
    return (r == 0) ? 23'd0 : (r == 1) ? 23'($urandom_range(0, 15)) : 23'($urandom);
  endfunction

  initial begin
    int t, n;
    logic [7:0] ea, eb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset data", dutOut(), '0);
    @(posedge clk); #1;
    reset = 0;
    out_ready = 1;
    @(negedge clk);
    check("in_ready after reset", in_ready, 1);
    @(posedge clk); #1;

    runOne("basic shift", 127, 0, 126, 0, 1, 0, 4'd1, mk(127, 27'h4000000, 27'h2000000, 0, 0, 1, 0, 1));
    runOne("saturate", 127, 0, 100, 1, 0, 0, 4'd2, mk(127, 27'h4000000, 27'h0000001, 0, 0, 0, 0, 2));
    runOne("guard round", 130, 0, 127, 7, 0, 1, 4'd3, mk(130, 27'h4000000, 27'h0800007, 0, 0, 0, 1, 3));
    runOne("subnormal b", 2, 0, 0, 23'h400000, 0, 0, 4'd4, mk(2, 27'h4000000, 27'h1000000, 0, 0, 0, 0, 4));
    runOne("both subnormal", 0, 23'h100, 0, 23'h200, 0, 0, 4'd5, mk(0, 27'h800, 27'h1000, 1, 0, 0, 0, 5));
    runOne("inf bypass", 8'hFF, 0, 127, 0, 0, 0, 4'd6, mk(255, 27'h4000000, 27'h1, 0, 1, 0, 0, 6));
    runOne("equal exp", 127, 3, 127, 5, 1, 1, 4'd7, mk(127, 27'h4000018, 27'h4000028, 1, 0, 1, 1, 7));
    runOne("b exp larger", 126, 0, 127, 0, 0, 0, 4'd8, mk(127, 27'h2000000, 27'h4000000, 1, 0, 0, 0, 8));

    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) sendOp(8'(120 + i), 23'(i), 8'(118), 23'(3 * i), 0, 1, 4'(i));
        in_valid = 0;
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        for (int k = 0; k < 3; k++) begin
          check("stall in_ready", in_ready, 0);
          check("stall head", {out_valid, out_tag}, {1'b1, 4'd0});
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("drain order", {out_valid, out_tag}, {1'b1, 4'(k)});
        end
      end
    join
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    out_ready = 0;
    sendOp(127, 1, 120, 2, 0, 0, 4'd9);
    sendOp(127, 3, 125, 4, 0, 0, 4'd10);
    in_valid = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("mid reset out_valid", out_valid, 0);
    check("mid reset data", dutOut(), '0);
    check("mid reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no stale output", out_valid, 0);
    end
    @(posedge clk); #1;

    for (int c = 0; c < 3000; c++) begin
      ea = rexp();
      if ($urandom_range(0, 1) == 1) begin
        t = int'(ea) + int'($urandom_range(0, 64)) - 32;
        eb = 8'((t < 0) ? 0 : (t > 255) ? 255 : t);
      end else eb = rexp();
      in_valid = ($urandom_range(0, 3) != 0);
      exp_a = ea; exp_b = eb; man_a = rman(); man_b = rman();
      sign_a = 1'($urandom); sign_b = 1'($urandom); in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined operand-alignment stage for the FP adder datapath; sits between unpack/classify and the mantissa ALU.
- Takes two unpacked operands of any IEEE-style format, selects the larger exponent, and right-shifts the smaller significand.
- Produces guard/round/sticky bits with exact sticky over all shifted-out bits, and handles subnormals and special-case bypass.
- Two-stage pipeline with a valid/ready handshake on both sides and a pass-through tag.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operation valid.
- in_ready  output  1  stage accepts input this cycle.
- sign_a, sign_b  input  1  operand signs, passed through.
- exp_a, exp_b  input  EXP_W  biased exponents.
- man_a, man_b  input  MAN_W  fraction fields.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  output operation valid.
- out_ready  input  1  downstream accepts output.
- exp_out  output  EXP_W  common (larger effective) exponent.
- aligned_a, aligned_b  output  MAN_W+4  {hidden, fraction, guard, round, sticky}.
- b_larger  output  1  B magnitude strictly greater than A (exponent, then mantissa).
- bypass  output  1  either operand is NaN, Inf or zero.
- sign_a_out, sign_b_out  output  1  registered signs.
- out_tag  output  TAG_W  registered tag.

Behaviour:
- AW = MAN_W+4.
- Aligned word layout: bit AW-1 = hidden bit; bits AW-2..3 = fraction; bit 2 = guard; bit 1 = round; bit 0 = sticky.
- Operand classification (input):
  - exp == 0 is subnormal/zero: hidden = 0, effective exponent = 1.
  - Otherwise hidden = 1, effective exponent = exp.
  - exp all-ones is Inf/NaN.
  - exp == 0 and man == 0 is zero.
- bypass = 1 if either operand is Inf/NaN or zero.
- When bypass = 1, all other outputs are still computed by the normal rules.
- Stage 1 (registered at end of cycle 1):
  - Compare effective exponents; diff = |eA - eB|; larger side selected.
  - exp_out = larger effective exponent; when both operands are subnormal, exp_out = 0.
  - b_larger = (eB > eA) or (eB == eA and man_b > man_a).
  - Build W = {hidden, man, 3'b000} for both operands.
- Stage 2 (registered at end of cycle 2):
  - Larger-exponent operand passes W unshifted.
  - Smaller operand: S = W >> diff, then S[0] |= OR of all bits shifted out.
  - If diff >= AW: result = {AW-1 zeros, |W}.
  - Equal exponents: neither operand is shifted; sticky bit = 0.
- Latency: 2 cycles from input accept to out_valid, when no stall.
- Throughput: 1 operation per cycle.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - Stage 1 advances when stage 2 is empty or stage 2 transfers in the same cycle.
  - in_ready = !s1_valid | s1_advance (combinational from out_ready; no skid buffer).
  - While out_valid = 1 and out_ready = 0, all outputs hold stable.
  - Simultaneous accept and drain in the same cycle is allowed: full throughput, no bubble.
- Reset:
  - s1_valid = s2_valid = 0, out_valid = 0.
  - All data outputs are zeroed (exp_out, aligned_*, b_larger, bypass, signs, out_tag).
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards in-flight operations; nothing is emitted for them.
- Widths: diff computed at EXP_W bits (unsigned, never negative after selection). Shift saturation is compared against AW at full width.

Test Plan (default params):
- Basic shift: A = 1.0 (exp 127, man 0), B = 0.5 (exp 126, man 0) -> after 2 cycles: exp_out = 127, aligned_a = 0x4000000, aligned_b = 0x2000000, b_larger = 0, bypass = 0.
- Sticky/saturation: A exp 127, B exp 100, man_b = 0x000001 (diff 27 = AW) -> aligned_b = 0x0000001, aligned_a = 0x4000000.
- Guard/round: A exp 130, B exp 127, man_b = 0x000007 (diff 3) -> aligned_b = 0x0800007; bits shifted out are 000, so sticky = the shifted-in LSB value 1.
- Subnormal: A exp 2 man 0; B exp 0 man 0x400000 -> eB = 1, diff = 1, exp_out = 2, aligned_b = 0x1000000. Both subnormal -> exp_out = 0, no shift.
- Special/compare: A exp 0xFF -> bypass = 1. Equal exponents 127 with man_b = 5 > man_a = 3 -> b_larger = 1, no shift.
- Flow control and reset:
  - Stream 4 ops back-to-back with out_ready = 0 for 3 cycles -> out_valid stays high, outputs stable, in_ready = 0 once both stages are full.
  - Release out_ready -> ops emerge in order, one per cycle, tags 0,1,2,3.
  - Assert reset with 2 ops in flight -> out_valid = 0 next cycle; no stale output after reset.
